seq_restoring_divider: RTL and testbench

- Multi-cycle unsigned restoring divider; the inverse companion of the team's combinational 4x4 array/Wallace multipliers.
- Takes a 2N-bit dividend (product width) and an N-bit divisor. Returns a 2N-bit quotient and an N-bit remainder.
- Retires one quotient bit per clock.
- Used in the adder/multiplier comparison testbenches, and as a round-trip checker: prod / B == A, rem == 0.

---
 rtl/seq_restoring_divider_if.sv | 25 ++
 rtl/seq_restoring_divider.sv | 147 ++++++++++++++
 tb/tb_seq_restoring_divider.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/seq_restoring_divider_if.sv
// Handshake bundle for seq_restoring_divider: operand channel in, result channel out.
interface seq_restoring_divider_if #(
  parameter int N = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] quotient;
  logic [N-1:0]   remainder;
  logic           div_by_zero;
  logic           busy;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, busy
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, busy
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Optional macro DIVIDER_ZERO_FASTPATH_EN: zero divisor finishes after a single cycle.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | shifting/subtracting, one quotient bit per edge
// DONE  | result held on out_valid until out_ready
module seq_restoring_divider #(
  parameter int N     = 4,
  parameter int CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  seq_restoring_divider_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(2*N-1);

  state_e         state_q, state_d;
  logic [2*N-1:0] q_q, q_d;
  logic [N-1:0]   d_q, d_d;
  logic [N:0]     r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*N-1:0] quotient_q, quotient_d;
  logic [N-1:0]   remainder_q, remainder_d;
  logic           dbz_q, dbz_d;
  logic           out_valid_q, out_valid_d;
  logic           in_ready_q, in_ready_d;
  logic           busy_q, busy_d;

  logic [N:0]     r_shift;
  logic           qbit;
  logic [N:0]     r_iter;
  logic [2*N-1:0] q_iter;
  logic [N-1:0]   zero_rem;

  always_comb begin
    r_shift = {r_q[N-1:0], q_q[2*N-1]};
    qbit    = (r_shift >= {1'b0, d_q});
    r_iter  = qbit ? (r_shift - {1'b0, d_q}) : r_shift;
    q_iter  = {q_q[2*N-2:0], qbit};
`ifdef DIVIDER_ZERO_FASTPATH_EN
    // Zero divisor finishes on its first RUN edge, so Q still holds the raw dividend.
    zero_rem = q_q[N-1:0];
`else
    zero_rem = r_iter[N-1:0];
`endif

    state_d     = state_q;
    q_d         = q_q;
    d_d         = d_q;
    r_d         = r_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          q_d        = bus.dividend;
          d_d        = bus.divisor;
          r_d        = '0;
          cnt_d      = '0;
          dbz_d      = (bus.divisor == '0);
          state_d    = RUN;
          busy_d     = 1'b1;
          in_ready_d = 1'b0;
`ifdef DIVIDER_ZERO_FASTPATH_EN
          if (bus.divisor == '0) cnt_d = LAST_CNT;
`endif
        end
      end
      RUN: begin
        q_d   = q_iter;
        r_d   = r_iter;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d     = DONE;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
          if (d_q == '0) begin
            quotient_d  = '1;
            remainder_d = zero_rem;
          end else begin
            quotient_d  = q_iter;
            remainder_d = r_iter[N-1:0];
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      q_q         <= '0;
      d_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      d_q         <= d_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed cases, exhaustive round trip, random ops.
module tb_seq_restoring_divider;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  seq_restoring_divider_if #(.N(N)) dif ();

  seq_restoring_divider #(.N(N), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_valid"}, 32'(dif.out_valid), 1'b0);
    chk({tag, "_in_ready"},  32'(dif.in_ready), 1'b1);
    chk({tag, "_busy"},      32'(dif.busy), 1'b0);
    chk({tag, "_dbz"},       32'(dif.div_by_zero), 1'b0);
    chk({tag, "_quotient"},  32'(dif.quotient), 0);
    chk({tag, "_remainder"}, 32'(dif.remainder), 0);
  endtask

  // Reference: plain integer division with the zero-divisor overrides.
  task automatic run_op(input int a, input int b, input int hold);
    int cyc, eq, er, elat;
    logic edbz;
    edbz = (b == 0);
    eq   = edbz ? (1 << (2*N)) - 1 : a / b;
    er   = edbz ? a % (1 << N) : a % b;
    elat = 2*N;
`ifdef DIVIDER_ZERO_FASTPATH_EN
    if (edbz) elat = 1;
`endif
    @(negedge clk);
    chk("in_ready_pre", 32'(dif.in_ready), 1'b1);
    dif.dividend = a[2*N-1:0];
    dif.divisor  = b[N-1:0];
    dif.in_valid = 1'b1;
    @(posedge clk);
    #1;
    dif.in_valid = 1'b0;
    chk("busy_run", 32'(dif.busy), 1'b1);
    cyc = 0;
    while (!dif.out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("latency", cyc, elat);
    chk("quotient", 32'(dif.quotient), eq);
    chk("remainder", 32'(dif.remainder), er);
    chk("div_by_zero", 32'(dif.div_by_zero), 32'(edbz));
    chk("in_ready_done", 32'(dif.in_ready), 1'b0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(dif.out_valid), 1'b1);
      chk("hold_quotient", 32'(dif.quotient), eq);
      chk("hold_remainder", 32'(dif.remainder), er);
    end
    @(negedge clk);
    dif.out_ready = 1'b1;
    @(posedge clk);
    #1;
    dif.out_ready = 1'b0;
    chk("post_hs_valid", 32'(dif.out_valid), 1'b0);
    chk("post_hs_ready", 32'(dif.in_ready), 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int a, b;
    dif.in_valid  = 1'b0;
    dif.out_ready = 1'b0;
    dif.dividend  = '0;
    dif.divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_op(143, 11, 0);
    run_op(200, 7, 0);
    run_op(255, 1, 0);
    run_op(13, 14, 0);
    run_op(0, 9, 0);
    run_op(100, 0, 0);
    run_op(50, 5, 0);

    // Backpressure with a stray operand offered while DONE.
    @(negedge clk);
    dif.dividend = 8'd99; dif.divisor = 4'd10; dif.in_valid = 1'b1;
    @(posedge clk);
    #1;
    dif.in_valid = 1'b0;
    repeat (2*N) @(posedge clk);
    #1;
    chk("bp_valid0", 32'(dif.out_valid), 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        dif.dividend = 8'd33; dif.divisor = 4'd2; dif.in_valid = 1'b1;
      end else begin
        dif.in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("bp_valid", 32'(dif.out_valid), 1'b1);
      chk("bp_quotient", 32'(dif.quotient), 9);
      chk("bp_remainder", 32'(dif.remainder), 9);
      chk("bp_in_ready", 32'(dif.in_ready), 1'b0);
    end
    dif.in_valid = 1'b0;
    @(negedge clk);
    dif.out_ready = 1'b1;
    @(posedge clk);
    #1;
    dif.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_queue_busy", 32'(dif.busy), 1'b0);
    chk("bp_no_queue_valid", 32'(dif.out_valid), 1'b0);

    // Reset pulse mid-RUN discards the operation.
    @(negedge clk);
    dif.dividend = 8'd221; dif.divisor = 4'd13; dif.in_valid = 1'b1;
    @(posedge clk);
    #1;
    dif.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_state("midrun");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2*N + 2) @(posedge clk);
    #1;
    chk("midrun_no_output", 32'(dif.out_valid), 1'b0);
    run_op(221, 13, 0);

    for (int ai = 0; ai < 16; ai++)
      for (int bi = 1; bi < 16; bi++)
        run_op(ai * bi, bi, 0);

    for (int k = 0; k < 120; k++) begin
      a = int'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 15));
      run_op(a, b, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
